// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, default width and op legality helper
package alu_pkg;
  localparam int ALU_N = 32;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  function automatic logic is_legal_op(input logic [2:0] op);
    return op inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLT};
  endfunction
endpackage

// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: two request channels and one tagged response channel
interface alu_rr_scheduler_if import alu_pkg::*; #(parameter int N = ALU_N);
  logic s0_valid, s0_ready, s1_valid, s1_ready;
  logic [N-1:0] s0_A, s0_B, s1_A, s1_B;
  logic [2:0] s0_op, s1_op;
  logic m_valid, m_ready, m_oVerflow, m_id, m_err;
  logic [N-1:0] m_Result;
  modport slave(
    input s0_valid, s0_A, s0_B, s0_op, s1_valid, s1_A, s1_B, s1_op, m_ready,
    output s0_ready, s1_ready, m_valid, m_Result, m_oVerflow, m_id, m_err
  );
  modport master(
    output s0_valid, s0_A, s0_B, s0_op, s1_valid, s1_A, s1_B, s1_op, m_ready,
    input s0_ready, s1_ready, m_valid, m_Result, m_oVerflow, m_id, m_err
  );
endinterface

// File: rtl/alu.sv
// alu: combinational ADD/SUB/AND/XOR/SLT with signed overflow for ADD/SUB
module alu import alu_pkg::*; #(
  parameter int N = ALU_N
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   ALUControl,
  output logic [N-1:0] Result,
  output logic         oVerflow
);
  logic [N-1:0] bb, sum;
  logic ovf_raw;
  // SUB and SLT share the subtractor (op bit 0 selects A + ~B + 1); SLT uses sign ^ overflow
  always_comb begin
    bb = ALUControl[0] ? ~B : B;
    sum = A + bb + N'(ALUControl[0]);
    ovf_raw = (A[N-1] == bb[N-1]) && (sum[N-1] != A[N-1]);
    oVerflow = (ALUControl == ALU_ADD || ALUControl == ALU_SUB) && ovf_raw;
    Result = (ALUControl == ALU_ADD || ALUControl == ALU_SUB) ? sum :
             (ALUControl == ALU_AND) ? A & B :
             (ALUControl == ALU_XOR) ? A ^ B :
             (ALUControl == ALU_SLT) ? N'(sum[N-1] ^ ovf_raw) : '0;
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one ALU with a registered, backpressured result
module alu_rr_scheduler import alu_pkg::*; #(
  parameter int N = ALU_N,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_rr_scheduler_if.slave bus,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] ovf_count
);
  logic gnt, xfer, alu_ovf;
  logic [N-1:0] a, b, alu_res;
  logic [2:0] op;
  logic m_valid_q, m_ovf_q, m_id_q, m_err_q, last_q;
  logic [N-1:0] m_res_q;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d, ovf_cnt_q, ovf_cnt_d;
  // Arbitration, operand mux (idles on s0) and saturating counter next-state
  always_comb begin
    gnt = bus.s1_valid & (~bus.s0_valid | ~last_q);
    xfer = rst_n & (~m_valid_q | bus.m_ready) & (bus.s0_valid | bus.s1_valid);
    a = gnt ? bus.s1_A : bus.s0_A;
    b = gnt ? bus.s1_B : bus.s0_B;
    op = gnt ? bus.s1_op : bus.s0_op;
    op_cnt_d = &op_cnt_q ? op_cnt_q : op_cnt_q + 1'b1;
    ovf_cnt_d = &ovf_cnt_q ? ovf_cnt_q : ovf_cnt_q + 1'b1;
  end
  alu #(.N(N)) u_alu (
    .A(a),
    .B(b),
    .ALUControl(op),
    .Result(alu_res),
    .oVerflow(alu_ovf)
  );
  // Result register: reload on transfer, drop valid on a bare consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_res_q <= '0;
      m_ovf_q <= 1'b0;
      m_id_q <= 1'b0;
      m_err_q <= 1'b0;
      last_q <= 1'b1;
      op_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else if (xfer) begin
      m_valid_q <= 1'b1;
      m_res_q <= alu_res;
      m_ovf_q <= alu_ovf;
      m_id_q <= gnt;
      m_err_q <= ~is_legal_op(op);
      last_q <= gnt;
      op_cnt_q <= op_cnt_d;
      if (alu_ovf) ovf_cnt_q <= ovf_cnt_d;
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end
  assign bus.s0_ready = xfer & ~gnt;
  assign bus.s1_ready = xfer & gnt;
  assign bus.m_valid = m_valid_q;
  assign bus.m_Result = m_res_q;
  assign bus.m_oVerflow = m_ovf_q;
  assign bus.m_id = m_id_q;
  assign bus.m_err = m_err_q;
  assign op_count = op_cnt_q;
  assign ovf_count = ovf_cnt_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed checks of arbitration, backpressure, ALU ops, reset and saturation
module tb_alu_rr_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] op_count, ovf_count;
  int n_chk = 0;
  int n_fail = 0;
  alu_rr_scheduler_if #(.N(32)) bus();
  alu_rr_scheduler #(.N(32), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .op_count(op_count),
    .ovf_count(ovf_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.m_ready = 1'b1;
    bus.s0_valid = 1'b1; bus.s0_op = 3'b000; bus.s0_A = 32'h7FFFFFFF; bus.s0_B = 32'h1;
    bus.s1_valid = 1'b0; bus.s1_op = 3'b000; bus.s1_A = 32'h0; bus.s1_B = 32'h0;
    #12;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_Result", bus.m_Result, 0);
    chk("rst_m_id", bus.m_id, 0);
    chk("rst_m_err", bus.m_err, 0);
    chk("rst_m_ovf", bus.m_oVerflow, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_ovf_count", ovf_count, 0);
    chk("rst_s0_ready", bus.s0_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("add_s0_ready", bus.s0_ready, 1);
    chk("add_s1_ready", bus.s1_ready, 0);
    tick();
    chk("add_m_valid", bus.m_valid, 1);
    chk("add_result", bus.m_Result, 64'h80000000);
    chk("add_ovf", bus.m_oVerflow, 1);
    chk("add_id", bus.m_id, 0);
    chk("add_ovf_count", ovf_count, 1);
    chk("add_op_count", op_count, 1);
    bus.m_ready = 1'b0;
    #1;
    chk("bp_s0_ready", bus.s0_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", bus.m_valid, 0);
    chk("arst_m_Result", bus.m_Result, 0);
    chk("arst_op_count", op_count, 0);
    chk("arst_ovf_count", ovf_count, 0);
    bus.m_ready = 1'b1;
    bus.s0_op = 3'b001; bus.s0_A = 32'd10; bus.s0_B = 32'd5;
    bus.s1_valid = 1'b1; bus.s1_op = 3'b010; bus.s1_A = 32'hF0F0F0F0; bus.s1_B = 32'h0F0F0F0F;
    rst_n = 1'b1;
    #1;
    chk("both_s0_ready", bus.s0_ready, 1);
    chk("both_s1_ready", bus.s1_ready, 0);
    tick();
    chk("sub_result", bus.m_Result, 5);
    chk("sub_id", bus.m_id, 0);
    bus.s0_valid = 1'b0;
    #1;
    chk("and_s1_ready", bus.s1_ready, 1);
    tick();
    chk("and_result", bus.m_Result, 0);
    chk("and_id", bus.m_id, 1);
    chk("and_op_count", op_count, 2);
    bus.s0_valid = 1'b1; bus.s0_op = 3'b000; bus.s0_A = 32'd1; bus.s0_B = 32'd2;
    bus.s1_op = 3'b000; bus.s1_A = 32'd3; bus.s1_B = 32'd4;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_id", bus.m_id, 64'(i % 2));
      chk("rr_result", bus.m_Result, (i % 2) ? 64'd7 : 64'd3);
    end
    chk("rr_op_count", op_count, 8);
    bus.s1_valid = 1'b0;
    bus.s0_op = 3'b011; bus.s0_A = 32'd10; bus.s0_B = 32'd10;
    #1;
    chk("xor_s0_ready", bus.s0_ready, 1);
    tick();
    chk("xor_result", bus.m_Result, 0);
    chk("xor_id", bus.m_id, 0);
    bus.s0_valid = 1'b0;
    bus.s1_valid = 1'b1;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_s1_ready", bus.s1_ready, 0);
      tick();
      chk("bp_m_valid", bus.m_valid, 1);
      chk("bp_result", bus.m_Result, 0);
      chk("bp_id", bus.m_id, 0);
    end
    bus.m_ready = 1'b1;
    #1;
    chk("rel_s1_ready", bus.s1_ready, 1);
    tick();
    chk("rel_result", bus.m_Result, 7);
    chk("rel_id", bus.m_id, 1);
    chk("rel_op_count", op_count, 10);
    bus.s1_op = 3'b110; bus.s1_A = 32'd5; bus.s1_B = 32'd7;
    tick();
    chk("ill_result", bus.m_Result, 0);
    chk("ill_err", bus.m_err, 1);
    chk("ill_ovf", bus.m_oVerflow, 0);
    chk("ill_id", bus.m_id, 1);
    bus.s1_op = 3'b101; bus.s1_A = 32'h80000000; bus.s1_B = 32'h7FFFFFFF;
    tick();
    chk("slt_result", bus.m_Result, 1);
    chk("slt_err", bus.m_err, 0);
    chk("slt_ovf", bus.m_oVerflow, 0);
    bus.s1_op = 3'b001; bus.s1_A = 32'h80000000; bus.s1_B = 32'h1;
    tick();
    chk("subovf_result", bus.m_Result, 64'h7FFFFFFF);
    chk("subovf_ovf", bus.m_oVerflow, 1);
    chk("subovf_ovf_count", ovf_count, 1);
    chk("subovf_op_count", op_count, 13);
    bus.s1_valid = 1'b0;
    bus.s0_valid = 1'b1; bus.s0_op = 3'b010; bus.s0_A = 32'hFF; bus.s0_B = 32'h0F;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sat_result", bus.m_Result, 64'h0F);
      chk("sat_op_count", op_count, (i < 2) ? 64'(14 + i) : 64'd15);
    end
    bus.s0_valid = 1'b0;
    tick();
    chk("idle_m_valid", bus.m_valid, 0);
    chk("idle_hold_result", bus.m_Result, 64'h0F);
    chk("idle_ovf_count", ovf_count, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
